// File: rtl/rng_pkg.sv
// Shared definitions for the 16-bit XNOR LFSR random-number path:
// word width, tap positions, the step function and the fetch FSM states.
package rng_pkg;

  localparam int RNG_W = 16;
  localparam logic [RNG_W-1:0] DEFAULT_SEED = 16'd5;

  localparam int TAP_A = 15;
  localparam int TAP_B = 14;
  localparam int TAP_C = 12;
  localparam int TAP_D = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_LOW,
    WAIT_HIGH
  } fetch_state_t;

  // One generator step: shift left, XNOR of the taps enters at bit 0.
  function automatic logic [RNG_W-1:0] lfsr_next(input logic [RNG_W-1:0] p);
    return {p[RNG_W-2:0], ~(p[TAP_A] ^ p[TAP_B] ^ p[TAP_C] ^ p[TAP_D])};
  endfunction

endpackage

// File: rtl/rng_fifo.sv
// Synchronous FIFO with binary pointers and an occupancy counter.
// The head entry is presented combinationally and reads as zero when empty.
module rng_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [LW-1:0]    level
);

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (level != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && (level != FULL);
  assign head    = valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array is deliberately not reset; level alone says which
  // entries are meaningful, so only pointers and occupancy need clearing.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rng_fetch_buffer.sv
// Requests words from the random generator, buffers them in a small FIFO and
// cross-checks every captured word against a local LFSR prediction.
module rng_fetch_buffer
  import rng_pkg::*;
#(
  parameter int               DEPTH   = 4,
  parameter logic [RNG_W-1:0] SEED    = DEFAULT_SEED,
  parameter int               TIMEOUT = 15
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic                       rng_en,
  input  logic                       rng_done,
  input  logic [RNG_W-1:0]           rng_data,
  output logic [RNG_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       mismatch,
  output logic                       timeout_err,
  output logic [15:0]                fetched
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] FULL      = LW'(DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [TW-1:0]    timer;
  logic [RNG_W-1:0] predictor;
  logic             capture;
  logic             expired;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    capture = (state == WAIT_HIGH) && rng_done;
    expired = (timer == TIMER_MAX) &&
              (((state == WAIT_LOW) && rng_done) || ((state == WAIT_HIGH) && !rng_done));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (fetch_en && (level != FULL)) state_next = REQ;
      REQ:       state_next = WAIT_LOW;
      WAIT_LOW:  if (!rng_done) state_next = WAIT_HIGH;
                 else if (expired) state_next = IDLE;
      WAIT_HIGH: if (capture || expired) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rng_en <= 1'b0;
      timer  <= '0;
    end else begin
      state  <= state_next;
      rng_en <= (state_next == REQ);
      if (state_next != state) timer <= '0;
      else if ((state == WAIT_LOW) || (state == WAIT_HIGH)) timer <= timer + TW'(1);
    end
  end

  // Predictor resyncs to the captured word so one bad word flags only once.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      predictor   <= SEED;
      mismatch    <= 1'b0;
      timeout_err <= 1'b0;
      fetched     <= '0;
    end else begin
      if (capture) begin
        predictor <= rng_data;
        fetched   <= fetched + 16'd1;
        if (rng_data != lfsr_next(predictor)) mismatch <= 1'b1;
      end
      if (expired) timeout_err <= 1'b1;
    end
  end

  rng_fifo #(
    .WIDTH(RNG_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .rst      (rst),
    .push     (capture),
    .push_data(rng_data),
    .pop      (out_ready),
    .head     (out_data),
    .valid    (out_valid),
    .level    (level)
  );

endmodule
